// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, fetches from imem over req/ack, presents one instruction to decode.
// Latency: an instruction acked in cycle N is on if_* in N+1; back-to-back fetch gives 1 instr/cycle.
// Backpressure: stall holds the output register; an ack arriving under stall parks in a one-entry skid (HOLD).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [15:0] if_imm16
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        r_discard;

  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_plus4;
  logic [15:0] r_if_imm16;

  logic        w_slot_free;
  logic        w_consume;
  logic [31:0] w_redir_pc;
  logic        w_load;
  logic [31:0] w_ld_instr;
  logic [31:0] w_ld_pc;

  // Word-align the redirect target; the two low address bits are never driven.
  assign w_redir_pc  = redirect_pc & ~32'd3;
  assign w_slot_free = !r_if_valid || !stall;
  assign w_consume   = r_if_valid && !stall;

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_req_addr;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign if_imm16    = r_if_imm16;

  // Select what (if anything) enters the output register: fresh memory data or the skid entry.
  always_comb begin
    w_load     = 1'b0;
    w_ld_instr = imem_rdata;
    w_ld_pc    = r_req_addr;
    if (!redirect_valid) begin
      if (r_state == S_REQ && imem_ack && !r_discard && w_slot_free) begin
        w_load = 1'b1;
      end else if (r_state == S_HOLD && w_slot_free) begin
        w_load     = 1'b1;
        w_ld_instr = r_skid_instr;
        w_ld_pc    = r_skid_pc;
      end
    end
  end

  // Output register: a redirect flushes it, a load refills it, a consume alone empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_valid    <= 1'b0;
      r_if_instr    <= 32'd0;
      r_if_pc       <= 32'd0;
      r_if_pc_plus4 <= 32'd4;
      r_if_imm16    <= 16'd0;
    end else if (redirect_valid) begin
      r_if_valid <= 1'b0;
    end else if (w_load) begin
      r_if_valid    <= 1'b1;
      r_if_instr    <= w_ld_instr;
      r_if_pc       <= w_ld_pc;
      r_if_pc_plus4 <= w_ld_pc + 32'd4;
      r_if_imm16    <= w_ld_instr[15:0];
    end else if (w_consume) begin
      r_if_valid <= 1'b0;
    end
  end

  // Fetch FSM: PC, request address, skid and the discard flag for a request orphaned by a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req_addr   <= 32'd0;
      r_skid_instr <= 32'd0;
      r_skid_pc    <= 32'd0;
      r_discard    <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= w_redir_pc;
      case (r_state)
        S_REQ: begin
          if (imem_ack) begin
            // The in-flight data lands now and is dropped; restart at the target at once.
            r_req_addr <= w_redir_pc;
            r_discard  <= 1'b0;
          end else begin
            // The request cannot be withdrawn, so swallow its data when it arrives.
            r_discard <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_REQ;
          r_req_addr <= w_redir_pc;
        end
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_REQ;
          r_req_addr <= r_pc;
        end
        S_REQ: begin
          if (imem_ack) begin
            if (r_discard) begin
              r_discard  <= 1'b0;
              r_req_addr <= r_pc;
            end else begin
              r_pc <= r_req_addr + 32'd4;
              if (w_slot_free) begin
                r_req_addr <= r_req_addr + 32'd4;
              end else begin
                r_skid_instr <= imem_rdata;
                r_skid_pc    <= r_req_addr;
                r_state      <= S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (w_slot_free) begin
            r_state    <= S_REQ;
            r_req_addr <= r_pc;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with RESET_PC=0x100 and a memory that can echo the address as data.
// Latency: all checks are taken 1 time unit after a rising edge.
// Backpressure: stall and imem_ack are driven directly by the step sequence.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [15:0] if_imm16;

  logic        echo_addr;
  logic [31:0] fixed_dat;
  int          total;
  int          bad;

  // Memory data: either the requested address itself or a fixed pattern.
  assign imem_rdata = echo_addr ? imem_addr : fixed_dat;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_imm16       (if_imm16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req},  32'd0);
    chk({tag, "_addr"},  imem_addr,          32'd0);
    chk({tag, "_valid"}, {31'd0, if_valid},  32'd0);
    chk({tag, "_instr"}, if_instr,           32'd0);
    chk({tag, "_pc"},    if_pc,              32'd0);
    chk({tag, "_pc4"},   if_pc_plus4,        32'd4);
    chk({tag, "_imm"},   {16'd0, if_imm16},  32'd0);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    imem_ack       = 1'b1;
    echo_addr      = 1'b1;
    fixed_dat      = 32'h0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state.
    tick();
    tick();
    chk_reset_outputs("rst0");
    rst = 1'b0;

    // One IDLE cycle, then streaming from 0x100 with single-cycle memory.
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h100);
    chk("first_nvalid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("w0_valid", {31'd0, if_valid}, 32'd1);
    chk("w0_pc", if_pc, 32'h100);
    chk("w0_instr", if_instr, 32'h100);
    chk("w0_pc4", if_pc_plus4, 32'h104);
    chk("w0_imm", {16'd0, if_imm16}, 32'h0100);
    chk("w1_addr", imem_addr, 32'h104);
    tick();
    chk("w1_pc", if_pc, 32'h104);
    chk("w1_valid", {31'd0, if_valid}, 32'd1);
    chk("w2_addr", imem_addr, 32'h108);

    // Stall for three cycles while 0x108 is acked: it parks in the skid.
    stall = 1'b1;
    tick();
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_pc", if_pc, 32'h104);
    chk("hold_instr", if_instr, 32'h104);
    chk("hold_valid", {31'd0, if_valid}, 32'd1);
    tick();
    chk("hold2_pc", if_pc, 32'h104);
    chk("hold2_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("hold3_pc", if_pc, 32'h104);
    stall = 1'b0;
    tick();
    chk("skid_pc", if_pc, 32'h108);
    chk("skid_instr", if_instr, 32'h108);
    chk("skid_req", {31'd0, imem_req}, 32'd1);
    chk("skid_next_addr", imem_addr, 32'h10C);
    tick();
    chk("after_skid_pc", if_pc, 32'h10C);
    chk("after_skid_addr", imem_addr, 32'h110);

    // Redirect to 0x2003 while a 3-wait request at 0x110 is outstanding.
    imem_ack       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2003;
    tick();
    redirect_valid = 1'b0;
    chk("disc_addr1", imem_addr, 32'h110);
    chk("disc_req1", {31'd0, imem_req}, 32'd1);
    chk("disc_valid1", {31'd0, if_valid}, 32'd0);
    tick();
    chk("disc_addr2", imem_addr, 32'h110);
    chk("disc_valid2", {31'd0, if_valid}, 32'd0);
    tick();
    chk("disc_addr3", imem_addr, 32'h110);
    imem_ack = 1'b1;
    tick();
    chk("disc_drop_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h2000);
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk("redir_valid", {31'd0, if_valid}, 32'd1);
    chk("redir_pc", if_pc, 32'h2000);
    chk("redir_next", imem_addr, 32'h2004);

    // Redirect to the top word, with the ack present: the address wraps to zero.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_nvalid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pc_plus4, 32'h0);
    chk("wrap_imm", {16'd0, if_imm16}, 32'hFFFC);
    chk("wrap_next", imem_addr, 32'h0);
    tick();
    chk("wrap0_pc", if_pc, 32'h0);
    chk("wrap0_pc4", if_pc_plus4, 32'h4);

    // Redirect and stall together with a valid output: redirect wins.
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    chk("rs_valid", {31'd0, if_valid}, 32'd0);
    chk("rs_addr", imem_addr, 32'h3000);
    tick();
    chk("rs_pc", if_pc, 32'h3000);

    // Reset mid-request, with a late ack that must be ignored.
    imem_ack = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk_reset_outputs("rst1");
    rst       = 1'b0;
    imem_ack  = 1'b1;
    echo_addr = 1'b0;
    fixed_dat = 32'hBADB_AD00;
    tick();
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h100);
    chk("restart_nvalid", {31'd0, if_valid}, 32'd0);
    echo_addr = 1'b1;
    tick();
    chk("restart_pc", if_pc, 32'h100);
    chk("restart_instr", if_instr, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
